// File: rtl/bit_pattern_generator.sv
// Serial bit-pattern generator: accepts a pattern word over valid/ready
// and shifts it out MSB-first with programmable length, repeats and gap.
module bit_pattern_generator #(
  parameter int   WIDTH      = 8,
  parameter int   REP_W      = 4,
  parameter int   GAP        = 2,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       pat_valid,
  output logic                       pat_ready,
  input  logic [WIDTH-1:0]           pattern,
  input  logic [$clog2(WIDTH+1)-1:0] len,
  input  logic [REP_W-1:0]           reps,
  input  logic                       abort,
  output logic                       out,
  output logic                       out_valid,
  output logic                       busy,
  output logic                       done,
  output logic [2:0]                 state
);

  localparam int LW = $clog2(WIDTH+1);
  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [GW-1:0] GAP_LD = GW'((GAP > 0) ? GAP - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SHIFT = 3'd1,
    S_GAP   = 3'd2,
    S_DONE  = 3'd3
  } state_t;

  state_t           r_state, w_state;
  logic [WIDTH-1:0] r_pat, w_pat;
  logic [IW-1:0]    r_lenm1, w_lenm1;
  logic [IW-1:0]    r_bit, w_bit;
  logic [REP_W-1:0] r_rep, w_rep;
  logic [GW-1:0]    r_gap, w_gap;

  logic [LW-1:0]    w_len_eff;
  logic [IW-1:0]    w_idx_ld;

  // len of 0 or above WIDTH both mean a full-width pattern
  always_comb begin
    w_len_eff = len;
    if (len == '0 || len > LW'(WIDTH))
      w_len_eff = LW'(WIDTH);
    w_idx_ld = IW'(w_len_eff - LW'(1));
  end

  always_comb begin
    w_state = r_state;
    w_pat   = r_pat;
    w_lenm1 = r_lenm1;
    w_bit   = r_bit;
    w_rep   = r_rep;
    w_gap   = r_gap;
    case (r_state)
      S_IDLE: begin
        if (pat_valid && !abort) begin
          w_pat   = pattern;
          w_lenm1 = w_idx_ld;
          w_bit   = w_idx_ld;
          w_rep   = reps;
          w_state = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (abort) begin
          w_state = S_IDLE;
        end else if (r_bit == '0) begin
          if (r_rep == '0) begin
            w_state = S_DONE;
          end else begin
            w_rep   = r_rep - 1'b1;
            w_bit   = r_lenm1;
            w_gap   = GAP_LD;
            w_state = (GAP > 0) ? S_GAP : S_SHIFT;
          end
        end else begin
          w_bit = r_bit - 1'b1;
        end
      end
      S_GAP: begin
        if (abort)
          w_state = S_IDLE;
        else if (r_gap == '0)
          w_state = S_SHIFT;
        else
          w_gap = r_gap - 1'b1;
      end
      S_DONE:  w_state = S_IDLE;
      default: w_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_pat   <= '0;
      r_lenm1 <= '0;
      r_bit   <= '0;
      r_rep   <= '0;
      r_gap   <= '0;
    end else begin
      r_state <= w_state;
      r_pat   <= w_pat;
      r_lenm1 <= w_lenm1;
      r_bit   <= w_bit;
      r_rep   <= w_rep;
      r_gap   <= w_gap;
    end
  end

  assign pat_ready = (r_state == S_IDLE);
  assign busy      = (r_state != S_IDLE);
  assign done      = (r_state == S_DONE);
  assign out_valid = (r_state == S_SHIFT);
  assign out       = out_valid ? r_pat[r_bit] : IDLE_LEVEL;
  assign state     = r_state;

endmodule

// File: tb/tb_bit_pattern_generator.sv
// Bench for bit_pattern_generator: GAP=2 and GAP=0 instances checked
// cycle by cycle against a queue-based stream model.
module tb_bit_pattern_generator;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] pv;
  logic [1:0] prdy, so, sv, bsy, dn;
  logic [2:0] st [2];
  logic [7:0] pattern;
  logic [3:0] len;
  logic [3:0] reps;
  logic       abort;

  int checks = 0;
  int errors = 0;
  logic [1:0] line_q [$];

  always #5 clk = ~clk;

  bit_pattern_generator #(.WIDTH(8), .REP_W(4), .GAP(2), .IDLE_LEVEL(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .pat_valid(pv[0]), .pat_ready(prdy[0]),
    .pattern(pattern), .len(len), .reps(reps), .abort(abort),
    .out(so[0]), .out_valid(sv[0]), .busy(bsy[0]), .done(dn[0]),
    .state(st[0])
  );

  bit_pattern_generator #(.WIDTH(8), .REP_W(4), .GAP(0), .IDLE_LEVEL(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .pat_valid(pv[1]), .pat_ready(prdy[1]),
    .pattern(pattern), .len(len), .reps(reps), .abort(abort),
    .out(so[1]), .out_valid(sv[1]), .busy(bsy[1]), .done(dn[1]),
    .state(st[1])
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int eff_len(input int l);
    return (l == 0 || l > 8) ? 8 : l;
  endfunction

  function automatic int gapv(input int k);
    return (k == 0) ? 2 : 0;
  endfunction

  // Full transfer on instance k; hold keeps pat_valid high afterwards.
  task automatic xfer(input int k, input logic [7:0] p, input int l,
                      input int r, input bit hold);
    logic [1:0] exp_q [$];
    logic [7:0] got, want;
    int L, cyc;
    L = eff_len(l);
    cyc = 0;
    while (prdy[k] !== 1'b1 && cyc < 60) begin
      step();
      cyc++;
    end
    checks++;
    if (prdy[k] !== 1'b1) begin
      errors++;
      $display("FAIL ready_wait k=%0d got %b want 1", k, prdy[k]);
    end
    pattern = p;
    len = l[3:0];
    reps = r[3:0];
    pv[k] = 1'b1;
    step();
    if (!hold) pv[k] = 1'b0;
    pattern = 8'($urandom);
    len = 4'($urandom);
    reps = 4'($urandom);
    for (int rr = 0; rr <= r; rr++) begin
      for (int i = L - 1; i >= 0; i--) exp_q.push_back({1'b1, p[i]});
      if (rr < r) repeat (gapv(k)) exp_q.push_back(2'b00);
    end
    line_q.delete();
    foreach (exp_q[j]) begin
      got  = {st[k], sv[k], so[k], dn[k], prdy[k], bsy[k]};
      want = {exp_q[j][1] ? 3'd1 : 3'd2, exp_q[j], 1'b0, 1'b0, 1'b1};
      line_q.push_back({sv[k], so[k]});
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL stream k=%0d p=%h len=%0d reps=%0d cyc=%0d got %b want %b",
                 k, p, l, r, j, got, want);
      end
      step();
    end
    got  = {st[k], sv[k], so[k], dn[k], prdy[k], bsy[k]};
    want = {3'd3, 2'b00, 1'b1, 1'b0, 1'b1};
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL done_cycle k=%0d got %b want %b", k, got, want);
    end
    step();
    got  = {st[k], sv[k], so[k], dn[k], prdy[k], bsy[k]};
    want = {3'd0, 2'b00, 1'b0, 1'b1, 1'b0};
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL idle_after k=%0d got %b want %b", k, got, want);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    pv = 2'b00;
    abort = 1'b0;
    pattern = '0;
    len = '0;
    reps = '0;
    #3;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if ({st[k], so[k], sv[k], bsy[k], dn[k], prdy[k]} !== 8'b000_0000_1) begin
        errors++;
        $display("FAIL reset k=%0d got %b want 00000001", k,
                 {st[k], so[k], sv[k], bsy[k], dn[k], prdy[k]});
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_single();
    xfer(0, 8'h16, 5, 0, 1'b0);
    xfer(1, 8'h16, 5, 0, 1'b0);
  endtask

  task automatic test_repeats();
    xfer(0, 8'h16, 5, 2, 1'b0);
    xfer(1, 8'h16, 5, 2, 1'b0);
  endtask

  task automatic test_len_clamp();
    xfer(0, 8'hA5, 0, 0, 1'b0);
    xfer(0, 8'hA5, 12, 0, 1'b0);
    xfer(1, 8'hA5, 12, 1, 1'b0);
  endtask

  task automatic test_abort();
    bit seen;
    pattern = 8'hFF;
    len = 4'd8;
    reps = 4'd0;
    pv[0] = 1'b1;
    step();
    pv[0] = 1'b0;
    step();
    step();
    checks++;
    if ({sv[0], so[0]} !== 2'b11) begin
      errors++;
      $display("FAIL abort_third_bit got %b want 11", {sv[0], so[0]});
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
    checks++;
    if ({st[0], so[0], sv[0], prdy[0]} !== 6'b000_001) begin
      errors++;
      $display("FAIL abort_idle got %b want 000001",
               {st[0], so[0], sv[0], prdy[0]});
    end
    seen = 1'b0;
    repeat (12) begin
      step();
      if (dn[0] !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL abort_no_done got done=1 want 0");
    end
    xfer(0, 8'h3C, 6, 1, 1'b0);
  endtask

  task automatic test_reset_mid();
    bit seen;
    pattern = 8'hA5;
    len = 4'd8;
    reps = 4'd1;
    pv = 2'b11;
    step();
    pv = 2'b00;
    step();
    #2 rst_n = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if ({st[k], so[k], sv[k], dn[k], prdy[k]} !== 7'b000_0001) begin
        errors++;
        $display("FAIL reset_mid k=%0d got %b want 0000001", k,
                 {st[k], so[k], sv[k], dn[k], prdy[k]});
      end
    end
    #2 rst_n = 1'b1;
    seen = 1'b0;
    repeat (12) begin
      step();
      if (dn !== 2'b00 || st[0] !== 3'd0 || st[1] !== 3'd0) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL reset_mid_quiet got activity want idle");
    end
  endtask

  task automatic test_loopback();
    logic [7:0] win;
    int hits [$];
    xfer(0, 8'hB4, 8, 3, 1'b0);
    win = '0;
    foreach (line_q[j]) begin
      win = {win[6:0], line_q[j][0]};
      if (line_q[j][1] && win == 8'hB4) hits.push_back(j);
    end
    checks++;
    if (hits.size() != 4) begin
      errors++;
      $display("FAIL loopback_count got %0d want 4", hits.size());
    end
    foreach (hits[i]) begin
      checks++;
      if (hits[i] != 7 + i * 10) begin
        errors++;
        $display("FAIL loopback_pos hit=%0d got %0d want %0d", i, hits[i], 7 + i * 10);
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 3; n++)
      xfer(1, 8'($urandom), int'($urandom_range(0, 15)),
           int'($urandom_range(0, 2)), 1'b1);
    pv[1] = 1'b0;
    step();
    checks++;
    if (st[1] !== 3'd0) begin
      errors++;
      $display("FAIL b2b_release got %0d want 0", st[1]);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 20; n++)
      xfer(int'($urandom_range(0, 1)), 8'($urandom),
           int'($urandom_range(0, 15)), int'($urandom_range(0, 3)), 1'b0);
  endtask

  initial begin
    test_reset();
    test_single();
    test_repeats();
    test_len_clamp();
    test_abort();
    test_reset_mid();
    test_loopback();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
